mont_modexp_ctrl: RTL
=====================

MONT_MODEXP_CTRL -- requirements
Module: mont_modexp_ctrl

Interface
REQ-001 SHALL have parameter K_BITS, default 8, giving the operand/modulus/exponent width in bits (R = 2^K_BITS).
REQ-002 SHALL have one clock and an asynchronous, active-high reset:
- i_Clk  input  1  rising-edge clock
- i_Rst  input  1  asynchronous reset, active-high
REQ-003 SHALL have these operation ports:
- i_Start  input  1  level request; operands are sampled on the first rising edge in IDLE where it is high
- i_Base  input  K_BITS  base X; caller guarantees X < m
- i_Exp  input  K_BITS  exponent E
- i_m  input  K_BITS  modulus; must be odd
- i_R2  input  K_BITS  precomputed R^2 mod m
- o_Result  output  K_BITS  X^E mod m, fully reduced
- o_Done  output  1  result valid
- o_Busy  output  1  operation in progress
- o_Err  output  1  even-modulus error
- o_MulCnt  output  $clog2(2*K_BITS+4)  count of multiplier operations in the last run
REQ-004 SHALL have these multiplier-side ports:
- o_Mul_Start  output  1  multiplier request
- o_Mul_A  output  K_BITS  multiplier operand A
- o_Mul_B  output  K_BITS  multiplier operand B
- o_Mul_m  output  K_BITS  multiplier modulus
- i_Mul_P  input  K_BITS  multiplier result A*B*R^-1 mod m
- i_Mul_Done  input  1  multiplier done

Function
REQ-005 SHALL register i_Base, i_Exp, i_m and i_R2 at operation start; input changes during the run SHALL be ignored.
REQ-006 SHALL drive o_Mul_m from the registered m for the whole run.
REQ-007 SHALL hold o_Mul_A and o_Mul_B stable while o_Mul_Start is high.
REQ-008 SHALL use this multiplier handshake for every multiplication:
- raise o_Mul_Start and hold it until i_Mul_Done is sampled high
- capture i_Mul_P in that same cycle and drop o_Mul_Start
- wait until i_Mul_Done is sampled low before the next request
REQ-009 SHALL use the states IDLE, TO_MONT, INIT_ACC, SQR, MUL, FROM_MONT, DONE, ERR.
- Each multiply state has a 1-bit phase: REQ while waiting for done high, REL while waiting for done low.
REQ-010 SHALL have TO_MONT compute Xm = MM(X, R2).
REQ-011 SHALL have INIT_ACC compute Acc = MM(1, R2).
REQ-012 SHALL scan exponent bits i = K_BITS-1 down to 0 most-significant first:
- SQR computes Acc = MM(Acc, Acc)
- if bit E[i] = 1, MUL then computes Acc = MM(Acc, Xm)
REQ-013 SHALL have FROM_MONT compute Result = MM(Acc, 1) after bit 0, then enter DONE.
REQ-014 SHALL, in DONE, assert o_Done and hold o_Result until i_Start is sampled low, then return to IDLE with o_Done low one cycle later.
REQ-015 SHALL, when i_m[0] = 0 at start, go IDLE -> ERR:
- issue no multiplication
- o_Err = 1, o_Done = 1, o_Result = 0, o_MulCnt = 0
- leave ERR under the same rule as DONE
REQ-016 SHALL keep o_Busy high in every state except IDLE, DONE and ERR.
REQ-017 SHALL clear o_MulCnt at start and increment it once per captured multiplier result.
REQ-018 SHALL ignore i_Start while o_Busy is high.
REQ-019 SHALL treat a spurious i_Mul_Done seen while o_Mul_Start is low in REQ phase, or in IDLE, as "not done" (ignored).
REQ-020 SHALL produce these results at the boundaries:
- E = 0 gives Result = 1 mod m
- m = 1 gives Result = 0
- X = 0 with E > 0 gives Result = 0

Reset
REQ-021 SHALL, on i_Rst high at any time (including mid-multiplication), asynchronously force:
- state IDLE
- o_Mul_Start, o_Done, o_Busy, o_Err = 0
- o_Result, o_MulCnt, o_Mul_A, o_Mul_B, o_Mul_m = 0
- the exponent bit index to K_BITS-1
REQ-022 SHALL start a new operation after reset release only on a fresh i_Start seen in IDLE.

Configuration
REQ-023 SHALL, with MODEXP_SKIP_LEADING_ZEROS_EN defined, skip exponent bits above the most-significant 1 (no SQR/MUL for them).
- E = 0 then goes INIT_ACC -> FROM_MONT directly.
- Multiplication count = 3 + (msb index + 1) + popcount(E); 3 when E = 0.
REQ-024 SHALL, with MODEXP_SKIP_LEADING_ZEROS_EN undefined, process all K_BITS bits.
- Multiplication count = 3 + K_BITS + popcount(E).
- o_Result SHALL be identical in both builds.

Structure
REQ-025 SHALL place the state enumeration, phase encoding and the MulCnt width function in the shared package mont_pkg.
REQ-026 SHALL contain no sub-module; the Montgomery multiplier datapath is instantiated beside this block at top level and connected through the o_Mul_*/i_Mul_* ports.

Verification
REQ-027 The bench SHALL cover these scenarios, with K_BITS = 8 and a real Montgomery multiplier attached:
- X=3, E=5, m=7, R2=2 -> o_Result=5; o_MulCnt=13 (8 with SKIP macro).
- X=2, E=10, m=225, R2=61 -> o_Result=124; o_Done held until i_Start drops.
- X=200, E=0, m=225, R2=61 -> o_Result=1; o_MulCnt=11 (3 with SKIP macro).
- m=224 (even) -> o_Err=1, o_Result=0, o_Mul_Start never asserted.
- i_Rst pulsed during an SQR REQ phase -> all outputs 0 immediately; X=3, E=5, m=7 rerun then returns 5.
- Multiplier done delayed by 20 cycles plus operand inputs toggled mid-run -> o_Result unchanged (5); o_Mul_A/B stable while o_Mul_Start is high.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared types for the Montgomery modular-exponentiation controller:
// FSM states, multiply phase encoding and the multiply-counter width.
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE, TO_MONT, INIT_ACC, SQR, MUL, FROM_MONT, DONE, ERR
  } state_t;

  // REQ: request raised, waiting for done high; REL: waiting for done low
  typedef enum logic {PH_REQ, PH_REL} phase_t;

  // Worst case is 3 + 2*K multiplies, always representable in this width
  function automatic int mulcnt_w(input int k);
    return $clog2(2*k + 4);
  endfunction

endpackage

// File: rtl/mont_modexp_ctrl_if.sv
// Operation-side and multiplier-side bundles of the modexp controller.
// The controller is the slave on the op bundle and the master on the mul bundle.
interface mont_op_if #(parameter int K_BITS = 8);
  localparam int CW = mont_pkg::mulcnt_w(K_BITS);

  logic              i_Start;
  logic [K_BITS-1:0] i_Base;
  logic [K_BITS-1:0] i_Exp;
  logic [K_BITS-1:0] i_m;
  logic [K_BITS-1:0] i_R2;
  logic [K_BITS-1:0] o_Result;
  logic              o_Done;
  logic              o_Busy;
  logic              o_Err;
  logic [CW-1:0]     o_MulCnt;

  modport master (output i_Start, i_Base, i_Exp, i_m, i_R2,
                  input  o_Result, o_Done, o_Busy, o_Err, o_MulCnt);
  modport slave  (input  i_Start, i_Base, i_Exp, i_m, i_R2,
                  output o_Result, o_Done, o_Busy, o_Err, o_MulCnt);
endinterface

interface mont_mul_if #(parameter int K_BITS = 8);
  logic              o_Mul_Start;
  logic [K_BITS-1:0] o_Mul_A;
  logic [K_BITS-1:0] o_Mul_B;
  logic [K_BITS-1:0] o_Mul_m;
  logic [K_BITS-1:0] i_Mul_P;
  logic              i_Mul_Done;

  modport master (output o_Mul_Start, o_Mul_A, o_Mul_B, o_Mul_m,
                  input  i_Mul_P, i_Mul_Done);
  modport slave  (input  o_Mul_Start, o_Mul_A, o_Mul_B, o_Mul_m,
                  output i_Mul_P, i_Mul_Done);
endinterface

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery
// multiplier. Define MODEXP_SKIP_LEADING_ZEROS_EN to skip exponent bits above the MSB 1.
module mont_modexp_ctrl
  import mont_pkg::*;
#(
  parameter int K_BITS = 8
) (
  input  logic      i_Clk,
  input  logic      i_Rst,
  mont_op_if.slave  op,
  mont_mul_if.master mul
);

  localparam int CW = mulcnt_w(K_BITS);
  localparam int IW = (K_BITS > 1) ? $clog2(K_BITS) : 1;
  localparam logic [K_BITS-1:0] ONE = K_BITS'(1);
  localparam logic [IW-1:0]     TOP = IW'(K_BITS - 1);

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [K_BITS-1:0] exp_q, exp_d;
  logic [K_BITS-1:0] m_q, m_d;
  logic [K_BITS-1:0] r2_q, r2_d;
  logic [K_BITS-1:0] xm_q, xm_d;
  logic [K_BITS-1:0] acc_q, acc_d;
  logic [K_BITS-1:0] res_q, res_d;
  logic [K_BITS-1:0] a_q, a_d;
  logic [K_BITS-1:0] b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mstart_q, mstart_d;
  logic              adv;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  function automatic logic [IW-1:0] msb_idx(input logic [K_BITS-1:0] e);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < K_BITS; i++)
      if (e[i]) r = IW'(i);
    return r;
  endfunction
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      phase_q  <= PH_REQ;
      exp_q    <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      xm_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= TOP;
      cnt_q    <= '0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      exp_q    <= exp_d;
      m_q      <= m_d;
      r2_q     <= r2_d;
      xm_q     <= xm_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mstart_q <= mstart_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    exp_d    = exp_q;
    m_d      = m_q;
    r2_d     = r2_q;
    xm_d     = xm_q;
    acc_d    = acc_q;
    res_d    = res_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mstart_d = mstart_q;
    adv      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op.i_Start) begin
          exp_d   = op.i_Exp;
          m_d     = op.i_m;
          r2_d    = op.i_R2;
          cnt_d   = '0;
          res_d   = '0;
          idx_d   = TOP;
          phase_d = PH_REQ;
          if (!op.i_m[0]) begin
            state_d = ERR;
          end else begin
            state_d  = TO_MONT;
            mstart_d = 1'b1;
            a_d      = op.i_Base;
            b_d      = op.i_R2;
          end
        end
      end

      DONE, ERR: begin
        if (!op.i_Start) state_d = IDLE;
      end

      default: begin
        if (phase_q == PH_REQ) begin
          // A done seen without our own request outstanding is not a completion
          if (mstart_q && mul.i_Mul_Done) begin
            mstart_d = 1'b0;
            phase_d  = PH_REL;
            cnt_d    = cnt_q + CW'(1);
            case (state_q)
              TO_MONT:   xm_d  = mul.i_Mul_P;
              FROM_MONT: res_d = mul.i_Mul_P;
              default:   acc_d = mul.i_Mul_P;
            endcase
          end
        end else if (!mul.i_Mul_Done) begin
          phase_d  = PH_REQ;
          mstart_d = 1'b1;
          case (state_q)
            TO_MONT: begin
              state_d = INIT_ACC;
              a_d     = ONE;
              b_d     = r2_q;
            end
            INIT_ACC: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
              if (exp_q == '0) begin
                state_d = FROM_MONT;
                a_d     = acc_q;
                b_d     = ONE;
              end else begin
                state_d = SQR;
                idx_d   = msb_idx(exp_q);
                a_d     = acc_q;
                b_d     = acc_q;
              end
`else
              state_d = SQR;
              a_d     = acc_q;
              b_d     = acc_q;
`endif
            end
            SQR: begin
              if (exp_q[idx_q]) begin
                state_d = MUL;
                a_d     = acc_q;
                b_d     = xm_q;
              end else begin
                adv = 1'b1;
              end
            end
            MUL: adv = 1'b1;
            default: begin
              state_d  = DONE;
              mstart_d = 1'b0;
            end
          endcase

          // Step to the next exponent bit, or leave the domain after bit 0
          if (adv) begin
            a_d = acc_q;
            if (idx_q == '0) begin
              state_d = FROM_MONT;
              b_d     = ONE;
            end else begin
              state_d = SQR;
              idx_d   = idx_q - IW'(1);
              b_d     = acc_q;
            end
          end
        end
      end
    endcase
  end

  assign op.o_Result     = res_q;
  assign op.o_Done       = (state_q == DONE) || (state_q == ERR);
  assign op.o_Err        = (state_q == ERR);
  assign op.o_Busy       = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign op.o_MulCnt     = cnt_q;
  assign mul.o_Mul_Start = mstart_q;
  assign mul.o_Mul_A     = a_q;
  assign mul.o_Mul_B     = b_q;
  assign mul.o_Mul_m     = m_q;

endmodule
